// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU's 16-bit memory bus.
//
// Serves word accesses (address bit 0 ignored) to an on-chip RAM and to a small MMIO window.
// Every read has a fixed single-cycle latency: a read strobe at edge N loads o_mem_rddata at
// edge N, and the value holds until the next read edge.
//
// MMIO window (byte offsets from MMIO_BASE, which must be 8-byte aligned and above the RAM):
//   +0 LED      read/write, drives o_led
//   +2 COUNT    read/write free-running timer counter
//   +4 COMPARE  read/write timer compare value
//   +6 STATUS   bit0 irq_pending (W1C), bit1 proto_err (W1C), bit2 timer_en (RW)
// Any other address outside RAM is unmapped: reads return 0 and writes are dropped.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   i_mem_addr    byte address from the CPU
//   i_mem_rd      read strobe
//   i_mem_wr      write strobe
//   i_mem_wrdata  write data
//   o_mem_rddata  registered read data
//   o_led         LED register
//   o_timer_irq   level interrupt (STATUS[0])
//   o_proto_err   sticky protocol error (STATUS[1])
//
// Build option: define MEM_INIT_EN to preload the RAM from the INIT_IMAGE word array
// (the image named by INIT_FILE). Without it the RAM starts undefined.

module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00,
  parameter string       INIT_FILE  = "mem_init.hex",
  parameter int unsigned INIT_WORDS = 1,
  parameter logic [15:0] INIT_IMAGE [INIT_WORDS] = '{default: 16'h0000}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic [15:0] o_led,
  output logic        o_timer_irq,
  output logic        o_proto_err
);

  localparam int unsigned RamWords = 1 << DEPTH_LOG2;

  localparam logic [1:0] OffLed     = 2'd0;
  localparam logic [1:0] OffCount   = 2'd1;
  localparam logic [1:0] OffCompare = 2'd2;
  localparam logic [1:0] OffStatus  = 2'd3;

  logic [15:0] mem [RamWords];

  // Keep the image name referenced; the contents come from INIT_IMAGE.
  logic unused_init_file;
  assign unused_init_file = (INIT_FILE.len() == 0);

`ifdef MEM_INIT_EN
  initial begin
    for (int unsigned i = 0; i < INIT_WORDS && i < RamWords; i++) begin
      mem[i] = INIT_IMAGE[i];
    end
  end
`endif

  logic [15:0] rddata_q, rddata_d;
  logic [15:0] led_q, led_d;
  logic [15:0] count_q, count_d;
  logic [15:0] compare_q, compare_d;
  logic        irq_q, irq_d;
  logic        perr_q, perr_d;
  logic        ten_q, ten_d;

  // Address decode
  logic                  ram_hit;
  logic                  mmio_hit;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [1:0]            mmio_off;
  logic                  unused_addr0;

  assign ram_hit      = (i_mem_addr >> (DEPTH_LOG2 + 1)) == 16'd0;
  assign mmio_hit     = (i_mem_addr[15:3] == MMIO_BASE[15:3]);
  assign ram_idx      = i_mem_addr[DEPTH_LOG2:1];
  assign mmio_off     = i_mem_addr[2:1];
  assign unused_addr0 = i_mem_addr[0];

  logic wr_led, wr_count, wr_compare, wr_status;
  assign wr_led     = i_mem_wr && mmio_hit && (mmio_off == OffLed);
  assign wr_count   = i_mem_wr && mmio_hit && (mmio_off == OffCount);
  assign wr_compare = i_mem_wr && mmio_hit && (mmio_off == OffCompare);
  assign wr_status  = i_mem_wr && mmio_hit && (mmio_off == OffStatus);

  // Read data source. Register values here are the pre-edge values, which gives the
  // read-before-write behaviour when rd and wr coincide.
  logic [15:0] rd_val;
  always_comb begin
    rd_val = 16'h0000;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else if (mmio_hit) begin
      unique case (mmio_off)
        OffLed:     rd_val = led_q;
        OffCount:   rd_val = count_q;
        OffCompare: rd_val = compare_q;
        OffStatus:  rd_val = {13'd0, ten_q, perr_q, irq_q};
        default:    rd_val = 16'h0000;
      endcase
    end
  end

  logic timer_hit;
  assign timer_hit = ten_q && (count_q == compare_q);

  always_comb begin
    rddata_d  = i_mem_rd ? rd_val : rddata_q;
    led_d     = wr_led ? i_mem_wrdata : led_q;
    compare_d = wr_compare ? i_mem_wrdata : compare_q;

    count_d = count_q;
    if (timer_hit) begin
      count_d = 16'h0000;
    end else if (ten_q) begin
      count_d = count_q + 16'd1;
    end
    if (wr_count) begin
      count_d = i_mem_wrdata;
    end

    // Hardware set takes priority over a same-cycle W1C clear.
    irq_d  = timer_hit || (irq_q && !(wr_status && i_mem_wrdata[0]));
    perr_d = (i_mem_rd && i_mem_wr) || (perr_q && !(wr_status && i_mem_wrdata[1]));
    ten_d  = wr_status ? i_mem_wrdata[2] : ten_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rddata_q  <= 16'h0000;
      led_q     <= 16'h0000;
      count_q   <= 16'h0000;
      compare_q <= 16'hFFFF;
      irq_q     <= 1'b0;
      perr_q    <= 1'b0;
      ten_q     <= 1'b0;
    end else begin
      rddata_q  <= rddata_d;
      led_q     <= led_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
      perr_q    <= perr_d;
      ten_q     <= ten_d;
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (i_mem_wr && ram_hit) begin
      mem[ram_idx] <= i_mem_wrdata;
    end
  end

  assign o_mem_rddata = rddata_q;
  assign o_led        = led_q;
  assign o_timer_irq  = irq_q;
  assign o_proto_err  = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] i_mem_addr;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [15:0] i_mem_wrdata;
  logic [15:0] o_mem_rddata;
  logic [15:0] o_led;
  logic        o_timer_irq;
  logic        o_proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] TbImage [2] = '{16'hC0DE, 16'h0001};

  mem_responder #(
    .INIT_WORDS (2),
    .INIT_IMAGE (TbImage)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_mem_wrdata (i_mem_wrdata),
    .o_mem_rddata (o_mem_rddata),
    .o_led        (o_led),
    .o_timer_irq  (o_timer_irq),
    .o_proto_err  (o_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    i_mem_addr   = addr;
    i_mem_wrdata = data;
    i_mem_wr     = 1'b1;
    @(posedge clk);
    #1;
    i_mem_wr = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    i_mem_addr = addr;
    i_mem_rd   = 1'b1;
    @(posedge clk);
    #1;
    i_mem_rd = 1'b0;
    data     = o_mem_rddata;
  endtask

  task automatic test_reset;
    n_tests++;
    if (o_mem_rddata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rddata got %h want 0000", o_mem_rddata);
    end
    n_tests++;
    if (o_led !== 16'h0000 || o_timer_irq !== 1'b0 || o_proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got led=%h irq=%b perr=%b want 0000/0/0",
               o_led, o_timer_irq, o_proto_err);
    end
  endtask

`ifdef MEM_INIT_EN
  task automatic test_mem_init;
    logic [15:0] d;
    do_read(16'h0000, d);
    n_tests++;
    if (d !== 16'hC0DE) begin
      n_fail++; $display("FAIL mem_init got %h want c0de", d);
    end
  endtask
`endif

  task automatic test_write_read;
    logic [15:0] d;
    do_write(16'h0010, 16'hBEEF);
    do_read(16'h0010, d);
    n_tests++;
    if (d !== 16'hBEEF || o_proto_err !== 1'b0) begin
      n_fail++; $display("FAIL write_read got %h perr=%b want beef perr=0", d, o_proto_err);
    end
    // Odd address maps to the same word.
    do_read(16'h0011, d);
    n_tests++;
    if (d !== 16'hBEEF) begin
      n_fail++; $display("FAIL odd_addr got %h want beef", d);
    end
  endtask

  task automatic test_back_to_back;
    do_write(16'h0040, 16'h1111);
    do_write(16'h0042, 16'h2222);
    @(negedge clk);
    i_mem_addr = 16'h0040;
    i_mem_rd   = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (o_mem_rddata !== 16'h1111) begin
      n_fail++; $display("FAIL b2b_first got %h want 1111", o_mem_rddata);
    end
    i_mem_addr = 16'h0042;
    @(posedge clk);
    #1;
    i_mem_rd = 1'b0;
    n_tests++;
    if (o_mem_rddata !== 16'h2222) begin
      n_fail++; $display("FAIL b2b_second got %h want 2222", o_mem_rddata);
    end
    i_mem_addr = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (o_mem_rddata !== 16'h2222) begin
      n_fail++; $display("FAIL rddata_hold got %h want 2222", o_mem_rddata);
    end
  endtask

  task automatic test_simultaneous;
    logic [15:0] d;
    do_write(16'h0020, 16'h1234);
    @(negedge clk);
    i_mem_addr   = 16'h0020;
    i_mem_wrdata = 16'h5678;
    i_mem_rd     = 1'b1;
    i_mem_wr     = 1'b1;
    @(posedge clk);
    #1;
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
    n_tests++;
    if (o_mem_rddata !== 16'h1234 || o_proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_wr_same got %h perr=%b want 1234 perr=1", o_mem_rddata, o_proto_err);
    end
    do_read(16'h0020, d);
    n_tests++;
    if (d !== 16'h5678 || o_proto_err !== 1'b1) begin
      n_fail++; $display("FAIL rd_after_rw got %h perr=%b want 5678 perr=1", d, o_proto_err);
    end
    do_write(16'hFF06, 16'h0002);
    n_tests++;
    if (o_proto_err !== 1'b0) begin
      n_fail++; $display("FAIL perr_clear got %b want 0", o_proto_err);
    end
  endtask

  task automatic test_timer;
    logic [15:0] d;
    do_write(16'hFF02, 16'h0000);
    do_write(16'hFF04, 16'h0005);
    do_write(16'hFF06, 16'h0004);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (o_timer_irq !== (i == 6)) begin
        n_fail++; $display("FAIL timer_irq_edge%0d got %b want %b", i, o_timer_irq, (i == 6));
      end
    end
    do_read(16'hFF02, d);
    n_tests++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL timer_count_wrap got %h want 0000", d);
    end
    do_read(16'hFF06, d);
    n_tests++;
    if (d !== 16'h0005) begin
      n_fail++; $display("FAIL timer_status got %h want 0005", d);
    end
    do_write(16'hFF06, 16'h0001);
    n_tests++;
    if (o_timer_irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear got %b want 0", o_timer_irq);
    end
    // Timer is now disabled: COUNT must hold.
    do_read(16'hFF02, d);
    repeat (3) @(posedge clk);
    do_read(16'hFF02, d);
    n_tests++;
    if (d !== 16'h0003) begin
      n_fail++; $display("FAIL count_hold got %h want 0003", d);
    end
  endtask

  task automatic test_led_unmapped;
    logic [15:0] d;
    do_write(16'hFF00, 16'h00A5);
    do_read(16'h8000, d);
    n_tests++;
    if (o_led !== 16'h00A5 || d !== 16'h0000) begin
      n_fail++; $display("FAIL led_unmapped got led=%h rd=%h want 00a5/0000", o_led, d);
    end
    do_write(16'h8000, 16'hFFFF);
    do_read(16'hFF04, d);
    n_tests++;
    if (o_led !== 16'h00A5 || d !== 16'h0005) begin
      n_fail++; $display("FAIL unmapped_wr got led=%h cmp=%h want 00a5/0005", o_led, d);
    end
    do_read(16'h0010, d);
    n_tests++;
    if (d !== 16'hBEEF) begin
      n_fail++; $display("FAIL unmapped_ram got %h want beef", d);
    end
    // Upper STATUS bits ignore writes; W1C bits stay clear.
    do_write(16'hFF06, 16'hFFF8);
    do_read(16'hFF06, d);
    n_tests++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL status_upper got %h want 0000", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    do_write(16'hFF06, 16'h0004);
    @(negedge clk);
    i_mem_addr = 16'h0030;
    i_mem_rd   = 1'b1;
    i_mem_wr   = 1'b1;
    @(posedge clk);
    #1;
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
    do_read(16'h0010, d);
    n_tests++;
    if (d !== 16'hBEEF || o_proto_err !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got %h perr=%b want beef perr=1", d, o_proto_err);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (o_mem_rddata !== 16'h0000 || o_led !== 16'h0000 || o_proto_err !== 1'b0 ||
        o_timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got rd=%h led=%h perr=%b irq=%b want 0000/0000/0/0",
               o_mem_rddata, o_led, o_proto_err, o_timer_irq);
    end
    @(negedge clk);
    reset = 1'b1;
    do_read(16'hFF02, d);
    n_tests++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count got %h want 0000", d);
    end
    do_read(16'hFF04, d);
    n_tests++;
    if (d !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_compare got %h want ffff", d);
    end
    do_read(16'hFF06, d);
    n_tests++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL reset_status got %h want 0000", d);
    end
    do_read(16'h0010, d);
    n_tests++;
    if (d !== 16'hBEEF) begin
      n_fail++; $display("FAIL ram_keep got %h want beef", d);
    end
  endtask

  initial begin
    reset        = 1'b0;
    i_mem_addr   = 16'h0000;
    i_mem_rd     = 1'b0;
    i_mem_wr     = 1'b0;
    i_mem_wrdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
`ifdef MEM_INIT_EN
    test_mem_init();
`endif
    test_write_read();
    test_back_to_back();
    test_simultaneous();
    test_timer();
    test_led_unmapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
